// File: rtl/spi_decoder_pkg.sv
// Shared types and constants for the SPI command decoder.
`timescale 1ns/1ps

package spi_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam int unsigned CMD_WRITE_BIT = 7;
    localparam int unsigned CMD_LEN       = 8;

    // Largest of three field widths; sizes the shared bit counter and RX shifter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with asynchronous active-low reset.
`timescale 1ns/1ps

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_command_decoder.sv
// SPI mode-0 frame decoder: command byte, address, data word(s).
// Optional feature: SPI_DECODER_AUTO_INCREMENT_EN (burst with address increment).
`timescale 1ns/1ps

module spi_command_decoder
    import spi_decoder_pkg::*;
#(
    parameter int unsigned START_ADDRESS_BIT_WIDTH = 14,
    parameter int unsigned MESSAGE_BIT_WIDTH       = 32,
    parameter int unsigned CODE_BIT_WIDTH          = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               spi_sck,
    input  logic                               spi_cs_n,
    input  logic                               spi_mosi,
    output logic                               spi_miso,
    output logic                               spi_miso_en,
    output logic                               program_memory_new,
    output logic                               read_memory_sync,
    output logic [CODE_BIT_WIDTH-1:0]          memory_code,
    output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
    output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
    input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out
);

    localparam int unsigned AW      = START_ADDRESS_BIT_WIDTH;
    localparam int unsigned MW      = MESSAGE_BIT_WIDTH;
    localparam int unsigned CNT_MAX = max3(CMD_LEN, AW, MW);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AW - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(MW - 1);

    logic sck_s, cs_n_s, mosi_s;
    logic sck_d, cs_n_d;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_MAX-2:0] rx;
    logic [CNT_MAX-1:0] rx_next;
    logic [MW-1:0]      tx;
    logic               is_write;
    logic               load_now;

    sync_2ff u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(spi_sck),  .q(sck_s));
    sync_2ff u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s));
    sync_2ff u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

    // Delayed copies of synchronised SCK / CS_N for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d  <= 1'b0;
            cs_n_d <= 1'b0;
        end else begin
            sck_d  <= sck_s;
            cs_n_d <= cs_n_s;
        end
    end

    // Edge strobes and the next value of the receive shifter.
    always_comb begin
        sck_rise = sck_s & ~sck_d;
        sck_fall = ~sck_s & sck_d;
        cs_fall  = ~cs_n_s & cs_n_d;
        cs_rise  = cs_n_s & ~cs_n_d;
        rx_next  = {rx, mosi_s};
    end

    // MISO is the TX shifter MSB, so it is a registered bit and reads 0 whenever TX is cleared.
    assign spi_miso = tx[MW-1];

    // Frame FSM with registered strobes, held message fields and TX shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            bit_cnt            <= '0;
            rx                 <= '0;
            tx                 <= '0;
            is_write           <= 1'b0;
            load_now           <= 1'b0;
            spi_miso_en        <= 1'b0;
            program_memory_new <= 1'b0;
            read_memory_sync   <= 1'b0;
            memory_code        <= '0;
            spi_address        <= '0;
            spi_data_in        <= '0;
        end else begin
            program_memory_new <= 1'b0;
            read_memory_sync   <= 1'b0;
            // Manager data is valid the cycle after the strobe; load one cycle later.
            load_now           <= read_memory_sync;

            if (cs_rise) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                tx          <= '0;
                spi_miso_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (sck_rise) begin
                            rx <= rx_next[CNT_MAX-2:0];
                            if (bit_cnt == CMD_LAST) begin
                                memory_code <= rx_next[CODE_BIT_WIDTH-1:0];
                                is_write    <= rx_next[CMD_WRITE_BIT];
                                state       <= ADDR;
                                bit_cnt     <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end

                    ADDR: begin
                        if (sck_rise) begin
                            rx <= rx_next[CNT_MAX-2:0];
                            if (bit_cnt == ADDR_LAST) begin
                                spi_address <= rx_next[AW-1:0];
                                state       <= DATA;
                                bit_cnt     <= '0;
                                if (!is_write) begin
                                    read_memory_sync <= 1'b1;
                                    spi_miso_en      <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end

                    DATA: begin
                        // The falling edge before the first rise of a word must not shift:
                        // the MSB loaded from spi_data_out is the first bit the master samples.
                        if (load_now) begin
                            tx <= spi_data_out;
                        end else if (sck_fall && !is_write && bit_cnt != '0) begin
                            tx <= {tx[MW-2:0], 1'b0};
                        end
`ifdef SPI_DECODER_AUTO_INCREMENT_EN
                        // Write address advances only after its strobe cycle, keeping it stable during the pulse.
                        if (program_memory_new) begin
                            spi_address <= spi_address + AW'(1);
                        end
`endif
                        if (sck_rise) begin
                            rx <= rx_next[CNT_MAX-2:0];
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (is_write) begin
                                    spi_data_in        <= rx_next[MW-1:0];
                                    program_memory_new <= 1'b1;
                                end
`ifdef SPI_DECODER_AUTO_INCREMENT_EN
                                if (!is_write) begin
                                    spi_address      <= spi_address + AW'(1);
                                    read_memory_sync <= 1'b1;
                                end
`else
                                state       <= DONE;
                                tx          <= '0;
                                spi_miso_en <= 1'b0;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end

                    DONE: begin
                        tx          <= '0;
                        spi_miso_en <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Scoreboard bench for spi_command_decoder: directed frames, queued expectations.
`timescale 1ns/1ps

module tb_spi_command_decoder;

    localparam int HALF = 8;  // clk cycles per SCK half period

    typedef struct packed {
        logic        wr;
        logic [3:0]  code;
        logic [13:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_en;
    logic        program_memory_new;
    logic        read_memory_sync;
    logic [3:0]  memory_code;
    logic [13:0] spi_address;
    logic [31:0] spi_data_in;
    logic [31:0] spi_data_out;

    logic [31:0] rd_word;
    exp_t        exp_q[$];
    int          n_cmp;
    int          n_err;
    int          n_wr_seen;
    int          n_rd_seen;
    logic        prev_strobe;

    spi_command_decoder #(
        .START_ADDRESS_BIT_WIDTH(14),
        .MESSAGE_BIT_WIDTH(32),
        .CODE_BIT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi_sck(spi_sck),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_miso_en(spi_miso_en),
        .program_memory_new(program_memory_new),
        .read_memory_sync(read_memory_sync),
        .memory_code(memory_code),
        .spi_address(spi_address),
        .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory manager read model: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (read_memory_sync) spi_data_out <= rd_word;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation for every strobe the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            prev_strobe = 1'b0;
        end else begin
            if (program_memory_new || read_memory_sync) begin
                if (program_memory_new) n_wr_seen++;
                if (read_memory_sync)   n_rd_seen++;
                check("strobe_exclusive", 64'(program_memory_new & read_memory_sync), 64'd0);
                check("strobe_back_to_back", 64'(prev_strobe), 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got wr=%0b addr=%0h expected no strobe",
                             program_memory_new, spi_address);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 64'(program_memory_new), 64'(e.wr));
                    check("strobe_code", 64'(memory_code), 64'(e.code));
                    check("strobe_addr", 64'(spi_address), 64'(e.addr));
                    if (e.wr) check("strobe_data", 64'(spi_data_in), 64'(e.data));
                end
            end
            prev_strobe = program_memory_new | read_memory_sync;
        end
    end

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        m = spi_miso;
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] cap);
        logic m;
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(v[i], m);
            cap = {cap[30:0], m};
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miso"},    64'(spi_miso), 64'd0);
        check({tag, "_miso_en"}, 64'(spi_miso_en), 64'd0);
        check({tag, "_prog"},    64'(program_memory_new), 64'd0);
        check({tag, "_rdsync"},  64'(read_memory_sync), 64'd0);
        check({tag, "_code"},    64'(memory_code), 64'd0);
        check({tag, "_addr"},    64'(spi_address), 64'd0);
        check({tag, "_data_in"}, 64'(spi_data_in), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        int          exp_wr;
        n_cmp = 0;
        n_err = 0;
        n_wr_seen = 0;
        n_rd_seen = 0;
        prev_strobe = 1'b0;
        rst_n = 1'b0;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        spi_data_out = '0;
        rd_word = '0;
        exp_wr = 0;

        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Single write: code 3, address 0x0005, data 0xDEADBEEF.
        exp_q.push_back('{wr: 1'b1, code: 4'd3, addr: 14'h0005, data: 32'hDEADBEEF});
        exp_wr++;
        cs_low();
        spi_bits(32'h83, 8, cap);
        spi_bits(32'h0005, 14, cap);
        spi_bits(32'hDEADBEEF, 32, cap);
        check("write_miso_idle", 64'(cap), 64'd0);
        cs_high();
        check("write_held_data", 64'(spi_data_in), 64'hDEADBEEF);

        // Single read: code 2, address 0x1234, data 0xCAFEF00D shifted out MSB first.
        rd_word = 32'hCAFEF00D;
        exp_q.push_back('{wr: 1'b0, code: 4'd2, addr: 14'h1234, data: 32'h0});
        cs_low();
        spi_bits(32'h02, 8, cap);
        spi_bits(32'h1234, 14, cap);
        spi_bits(32'hCAFEF00D, 1, cap);
        check("read_miso_en", 64'(spi_miso_en), 64'd1);
        check("read_first_bit", 64'(cap), 64'd1);
        spi_bits(32'h0, 31, cap);
        check("read_miso_word", 64'(cap), 64'h4AFEF00D);
        cs_high();
        check("read_miso_en_off", 64'(spi_miso_en), 64'd0);

        // Abort a write after 17 data bits: no strobe, earlier data held.
        cs_low();
        spi_bits(32'h81, 8, cap);
        spi_bits(32'h0100, 14, cap);
        spi_bits(32'h1FFFF, 17, cap);
        cs_high();
        check("abort_miso_en", 64'(spi_miso_en), 64'd0);
        check("abort_addr_held", 64'(spi_address), 64'h0100);
        check("abort_code_held", 64'(memory_code), 64'd1);
        check("abort_data_kept", 64'(spi_data_in), 64'hDEADBEEF);

        // Abort a read after 5 data bits: MISO output released.
        rd_word = 32'h80000001;
        exp_q.push_back('{wr: 1'b0, code: 4'd5, addr: 14'h0042, data: 32'h0});
        cs_low();
        spi_bits(32'h05, 8, cap);
        spi_bits(32'h0042, 14, cap);
        spi_bits(32'h0, 5, cap);
        check("abort_rd_bits", 64'(cap), 64'h10);
        check("abort_rd_en_on", 64'(spi_miso_en), 64'd1);
        cs_high();
        check("abort_rd_en_off", 64'(spi_miso_en), 64'd0);
        check("abort_rd_miso", 64'(spi_miso), 64'd0);

        // Three-word write burst at 0x3FFF.
        exp_q.push_back('{wr: 1'b1, code: 4'd4, addr: 14'h3FFF, data: 32'h11111111});
        exp_wr++;
`ifdef SPI_DECODER_AUTO_INCREMENT_EN
        exp_q.push_back('{wr: 1'b1, code: 4'd4, addr: 14'h0000, data: 32'h22222222});
        exp_q.push_back('{wr: 1'b1, code: 4'd4, addr: 14'h0001, data: 32'h33333333});
        exp_wr += 2;
`endif
        cs_low();
        spi_bits(32'hF4, 8, cap);
        spi_bits(32'h3FFF, 14, cap);
        spi_bits(32'h11111111, 32, cap);
        spi_bits(32'h22222222, 32, cap);
        check("burst_w2_miso", 64'(cap), 64'd0);
        check("burst_w2_en", 64'(spi_miso_en), 64'd0);
        spi_bits(32'h33333333, 32, cap);
        check("burst_w3_miso", 64'(cap), 64'd0);
        cs_high();
`ifdef SPI_DECODER_AUTO_INCREMENT_EN
        check("burst_last_data", 64'(spi_data_in), 64'h33333333);
`else
        check("burst_last_data", 64'(spi_data_in), 64'h11111111);
`endif

        // Reset asserted during the address phase clears all outputs immediately.
        cs_low();
        spi_bits(32'h87, 8, cap);
        spi_bits(32'h3F, 6, cap);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        exp_q.push_back('{wr: 1'b1, code: 4'd6, addr: 14'h0ABC, data: 32'h0BADF00D});
        exp_wr++;
        cs_low();
        spi_bits(32'h86, 8, cap);
        spi_bits(32'h0ABC, 14, cap);
        spi_bits(32'h0BADF00D, 32, cap);
        cs_high();

        repeat (20) @(negedge clk);
        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        check("write_strobe_count", 64'(n_wr_seen), 64'(exp_wr));
        check("read_strobe_count", 64'(n_rd_seen), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
